// File: rtl/uart_frame_tx.sv
// UART transmitter: start, 8 data bits LSB-first, optional even parity, stop, with a one-entry holding buffer.
// Define UART_TX_PARITY_EN for the 11-bit frame with parity; leave it undefined for the 10-bit frame.
module uart_frame_tx #(
  parameter int CLK_PER_BIT = 16,
  parameter int DATA_W      = 8
) (
  input  logic              clk_1M8,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              txd,
  output logic              tx_busy,
  output logic              frame_done
);

  if (DATA_W != 8 || CLK_PER_BIT < 2 || CLK_PER_BIT > 255) begin : g_bad_param
    $error("uart_frame_tx: DATA_W must be 8 and CLK_PER_BIT must be 2..255");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [7:0] BAUD_LAST = 8'(CLK_PER_BIT - 1);
  localparam logic [7:0] BAUD_PRE  = 8'(CLK_PER_BIT - 2);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_W - 1);

  state_t            state;
  logic [7:0]        baud_cnt;
  logic [2:0]        bit_cnt;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] shift_q;
`ifdef UART_TX_PARITY_EN
  logic              par_q;
`endif

  logic bit_end;
  logic load;

  // tx_ready low means the holding buffer is full; it drains in IDLE or at the end of STOP.
  assign bit_end = (baud_cnt == BAUD_LAST);
  assign load    = !tx_ready && ((state == IDLE) || ((state == STOP) && bit_end));

  // NOTE: every register here, data included, is cleared by the async reset so a mid-frame
  // reset leaves no stale byte behind; all state updates use non-blocking assignments.
  always_ff @(posedge clk_1M8 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      hold_q     <= '0;
      shift_q    <= '0;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
      tx_ready   <= 1'b1;
      txd        <= 1'b1;
      tx_busy    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == STOP) && (baud_cnt == BAUD_PRE);

      if (tx_valid && tx_ready) begin
        hold_q   <= tx_data;
        tx_ready <= 1'b0;
      end

      if (load) begin
        state    <= START;
        shift_q  <= hold_q;
`ifdef UART_TX_PARITY_EN
        par_q    <= ^hold_q;
`endif
        tx_ready <= 1'b1;
        txd      <= 1'b0;
        tx_busy  <= 1'b1;
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end else if (state != IDLE) begin
        if (!bit_end) begin
          baud_cnt <= baud_cnt + 8'd1;
        end else begin
          baud_cnt <= '0;
          unique case (state)
            START: begin
              state <= DATA;
              txd   <= shift_q[0];
            end
            DATA: begin
              if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                state <= PARITY;
                txd   <= par_q;
`else
                state <= STOP;
                txd   <= 1'b1;
`endif
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
                shift_q <= shift_q >> 1;
                txd     <= shift_q[1];
              end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
              state <= STOP;
              txd   <= 1'b1;
            end
`endif
            STOP: begin
              state   <= IDLE;
              tx_busy <= 1'b0;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx: accepted bytes go to a scoreboard queue, and a line
// monitor decodes each frame mid-bit and compares it against the queue head.
module tb_uart_frame_tx;

  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  typedef logic [10:0] frame_t;
  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  logic       clk_1M8 = 1'b0;
  logic       rst_n   = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       txd;
  logic       tx_busy;
  logic       frame_done;

  uart_frame_tx #(.CLK_PER_BIT(CPB), .DATA_W(8)) dut (
    .clk_1M8    (clk_1M8),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .txd        (txd),
    .tx_busy    (tx_busy),
    .frame_done (frame_done)
  );

  always #5 clk_1M8 = ~clk_1M8;

  int     total = 0;
  int     bad   = 0;
  frame_t sb_q[$];
  logic   cur_par = 1'b0;
  int     accept_cnt = 0;
  int     frames_seen = 0;
  int     busy_cnt = 0;
  int     busy_falls = 0;
  int     ready_cnt = 0;
  int     fd_cnt = 0;
  logic   busy_d = 1'b0;
  vec_t   vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic frame_t expect_frame(input logic [7:0] d, input logic p);
    frame_t f;
    f      = '0;
    f[0]   = 1'b0;
    f[8:1] = d;
    f[9]   = (NBITS == 11) ? p : 1'b1;
    f[10]  = (NBITS == 11);
    return f;
  endfunction

  always @(posedge clk_1M8) begin
    if (rst_n && tx_valid && tx_ready) begin
      sb_q.push_back(expect_frame(tx_data, cur_par));
      accept_cnt++;
    end
  end

  always @(negedge clk_1M8) begin
    if (tx_busy) busy_cnt++;
    if (busy_d && !tx_busy) busy_falls++;
    busy_d = tx_busy;
    if (tx_ready) ready_cnt++;
    if (frame_done) fd_cnt++;
  end

  // Line monitor: a low txd outside a frame marks cycle 1 of a start bit.
  initial begin
    forever begin
      @(negedge clk_1M8);
      if (rst_n && txd === 1'b0) begin
        frame_t rx;
        frame_t exp;
        logic   have_exp;
        logic   ok_done;
        logic   ok_busy;
        logic   aborted;
        rx = '0;
        ok_done = 1'b1;
        ok_busy = 1'b1;
        aborted = 1'b0;
        have_exp = (sb_q.size() > 0);
        exp = have_exp ? sb_q.pop_front() : 'x;
        for (int c = 1; c <= FRAME; c++) begin
          if (c > 1) @(negedge clk_1M8);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          if ((c - 1) % CPB == CPB / 2) rx[(c - 1) / CPB] = txd;
          if (frame_done !== (c == FRAME)) ok_done = 1'b0;
          if (tx_busy !== 1'b1) ok_busy = 1'b0;
        end
        if (!aborted) begin
          frames_seen++;
          check("frame_expected", 32'(have_exp), 32'd1);
          check("frame_bits", 32'(rx), 32'(exp));
          check("frame_done_pos", 32'(ok_done), 32'd1);
          check("busy_in_frame", 32'(ok_busy), 32'd1);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic p);
    logic got;
    got = 1'b0;
    tx_data  = d;
    cur_par  = p;
    tx_valid = 1'b1;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(posedge clk_1M8);
      if (tx_ready) begin
        got = 1'b1;
        break;
      end
    end
    #1;
    if (!got) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 6 * FRAME; i++) begin
      @(posedge clk_1M8);
      #1;
      if (!tx_busy && tx_ready && txd === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
    check({name, "_queue_empty"}, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic quiet(input string name, input int n);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_1M8);
      if (txd !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || frame_done !== 1'b0) ok = 1'b0;
    end
    check(name, 32'(ok), 32'd1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int frames0;
    vecs[0] = '{8'h55, 1'b0};
    vecs[1] = '{8'h80, 1'b1};
    vecs[2] = '{8'h01, 1'b1};
    vecs[3] = '{8'hA3, 1'b0};
    vecs[4] = '{8'hC4, 1'b1};
    vecs[5] = '{8'hFF, 1'b0};
    vecs[6] = '{8'h00, 1'b0};
    vecs[7] = '{8'h3C, 1'b0};

    repeat (3) @(negedge clk_1M8);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;

    quiet("idle_500", 500);

    // Single byte: accept edge, then start bit one edge later.
    @(negedge clk_1M8);
    tx_data  = 8'h55;
    cur_par  = 1'b0;
    tx_valid = 1'b1;
    @(posedge clk_1M8);
    #1;
    tx_valid = 1'b0;
    check("accept_ready_low", 32'(tx_ready), 32'd0);
    check("txd_before_start", 32'(txd), 32'd1);
    @(posedge clk_1M8);
    #1;
    check("start_latency_txd", 32'(txd), 32'd0);
    check("start_busy", 32'(tx_busy), 32'd1);
    check("drain_ready", 32'(tx_ready), 32'd1);
    wait_idle("idle_after_55");

    // Two bytes back-to-back: busy stays high for exactly two frames.
    busy_cnt   = 0;
    busy_falls = 0;
    send(8'h80, 1'b1);
    send(8'h01, 1'b1);
    tx_valid = 1'b0;
    wait_idle("idle_after_pair");
    check("pair_busy_cycles", 32'(busy_cnt), 32'(2 * FRAME));
    check("pair_busy_falls", 32'(busy_falls), 32'd1);

    // Valid held high: one accept per frame, ready high for one cycle per drain.
    accept_cnt = 0;
    fd_cnt     = 0;
    send(8'hA3, 1'b0);
    ready_cnt = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(posedge clk_1M8);
      #1;
      if (fd_cnt >= 3) break;
    end
    check("held_fd_count", 32'(fd_cnt), 32'd3);
    check("held_ready_cycles", 32'(ready_cnt), 32'd3);
    check("held_accepts", 32'(accept_cnt), 32'd4);
    tx_valid = 1'b0;
    wait_idle("idle_after_held");

    // Table of bytes sent back-to-back.
    frames0 = frames_seen;
    for (int i = 0; i < 8; i++) send(vecs[i].data, vecs[i].par);
    tx_valid = 1'b0;
    wait_idle("idle_after_table");
    check("table_frames", 32'(frames_seen - frames0), 32'd8);

    // Reset in the middle of data bit 4 with a byte buffered.
    send(8'hFF, 1'b0);
    send(8'h00, 1'b0);
    tx_valid = 1'b0;
    repeat (86) @(posedge clk_1M8);
    #3;
    check("pre_rst_busy", 32'(tx_busy), 32'd1);
    check("pre_rst_ready", 32'(tx_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("async_rst_txd", 32'(txd), 32'd1);
    check("async_rst_ready", 32'(tx_ready), 32'd1);
    check("async_rst_busy", 32'(tx_busy), 32'd0);
    repeat (3) @(negedge clk_1M8);
    sb_q.delete();
    rst_n  = 1'b1;
    fd_cnt = 0;
    frames0 = frames_seen;
    quiet("post_rst_quiet", 500);
    check("post_rst_no_done", 32'(fd_cnt), 32'd0);
    check("post_rst_no_frame", 32'(frames_seen - frames0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
